// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue constants: the classic define.v macros plus typed package equivalents.
// Compile this file first; the other fetch-queue files only import the package.
`ifndef FQ_DEFINES_SV
`define FQ_DEFINES_SV
`define INSTR_WIDTH   32
`define PC_WIDTH      32
`define history_WIDTH 8
`define NOP_INSTR_VAL 32'h0000_0013
`define nop_PC        32'h0000_0000
`define nop_nPC       32'h0000_0000
`define NOP_COMMIT_VAL 1'b0
`define FQ_DEPTH      4
`endif

package fetch_queue_pkg;

  localparam int FQ_DEPTH_DEF = `FQ_DEPTH;
  localparam int FQ_INSTR_W   = `INSTR_WIDTH;
  localparam int FQ_PC_W      = `PC_WIDTH;
  localparam int FQ_HIST_W    = `history_WIDTH;

  localparam logic [FQ_INSTR_W-1:0] NOP_INSTR  = `NOP_INSTR_VAL;
  localparam logic [FQ_PC_W-1:0]    NOP_PC     = `nop_PC;
  localparam logic [FQ_PC_W-1:0]    NOP_NPC    = `nop_nPC;
  localparam logic                  NOP_COMMIT = `NOP_COMMIT_VAL;

  // Packed entry: {instr, PC, nPC, commit, train_predict, train_vaild, history}.
  function automatic int fq_entry_w(input int instr_w, input int pc_w, input int hist_w);
    return instr_w + 2 * pc_w + 3 + hist_w;
  endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: synchronous write, asynchronous read.
// Deliberately unreset; the queue masks stale contents with nop values when empty.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue: circular buffer with valid/ready on both sides, one-cycle flush,
// first-word-fall-through head that reads as a nop bubble whenever the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH    = FQ_DEPTH_DEF,
  parameter int INSTR_W  = FQ_INSTR_W,
  parameter int PC_W     = FQ_PC_W,
  parameter int HIST_W   = FQ_HIST_W,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     F_valid_i,
  output logic                     F_ready_o,
  input  logic [INSTR_W-1:0]       F_instr_i,
  input  logic [PC_W-1:0]          F_PC_i,
  input  logic [PC_W-1:0]          F_nPC_i,
  input  logic                     F_commit_i,
  input  logic                     F_train_predict_i,
  input  logic                     F_train_vaild_i,
  input  logic [HIST_W-1:0]        F_train_history_i,
  output logic                     D_valid_o,
  input  logic                     D_ready_i,
  output logic [INSTR_W-1:0]       FD_instr_o,
  output logic [PC_W-1:0]          FD_PC_o,
  output logic [PC_W-1:0]          FD_nPC_o,
  output logic                     FD_commit_o,
  output logic                     FD_train_predict_o,
  output logic                     FD_train_vaild_o,
  output logic [HIST_W-1:0]        FD_train_history_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     afull_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = fq_entry_w(INSTR_W, PC_W, HIST_W);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_rdata;

  logic [INSTR_W-1:0] w_head_instr;
  logic [PC_W-1:0]    w_head_pc;
  logic [PC_W-1:0]    w_head_npc;
  logic               w_head_commit;
  logic               w_head_predict;
  logic               w_head_vaild;
  logic [HIST_W-1:0]  w_head_hist;

  // Both handshakes derive from registered occupancy only, so ready never depends on D_ready_i.
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign F_ready_o = ~w_full;
  assign D_valid_o = ~w_empty;
  assign count_o   = r_count;
  assign afull_o   = (r_count >= CW'(AFULL_TH));

  assign w_push = F_valid_i & F_ready_o & ~flush_i;
  assign w_pop  = D_valid_o & D_ready_i & ~flush_i;

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign w_wdata = {F_instr_i, F_PC_i, F_nPC_i, F_commit_i,
                    F_train_predict_i, F_train_vaild_i, F_train_history_i};

  fq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_storage (
    .clk_i   (clk_i),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign {w_head_instr, w_head_pc, w_head_npc, w_head_commit,
          w_head_predict, w_head_vaild, w_head_hist} = w_rdata;

  // Empty queue presents a legal bubble so decode may ignore D_valid_o.
  always_comb begin
    FD_instr_o         = INSTR_W'(NOP_INSTR);
    FD_PC_o            = PC_W'(NOP_PC);
    FD_nPC_o           = PC_W'(NOP_NPC);
    FD_commit_o        = NOP_COMMIT;
    FD_train_predict_o = 1'b0;
    FD_train_vaild_o   = 1'b0;
    FD_train_history_o = '0;
    if (D_valid_o) begin
      FD_instr_o         = w_head_instr;
      FD_PC_o            = w_head_pc;
      FD_nPC_o           = w_head_npc;
      FD_commit_o        = w_head_commit;
      FD_train_predict_o = w_head_predict;
      FD_train_vaild_o   = w_head_vaild;
      FD_train_history_o = w_head_hist;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed test-plan scenarios plus random traffic,
// all checked against a queue-based reference model of the fetch/decode contract.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH    = 4;
  localparam int IW       = FQ_INSTR_W;
  localparam int PW       = FQ_PC_W;
  localparam int HW       = FQ_HIST_W;
  localparam int AFULL_TH = DEPTH - 1;
  localparam int CW       = $clog2(DEPTH) + 1;

  typedef struct {
    logic [IW-1:0] instr;
    logic [PW-1:0] pc;
    logic [PW-1:0] npc;
    logic          commit;
    logic          pred;
    logic          tv;
    logic [HW-1:0] hist;
  } ent_t;

  ent_t model_q[$];

  logic          clk_i = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0;
  logic          F_valid_i = 1'b0;
  logic          F_ready_o;
  logic [IW-1:0] F_instr_i = '0;
  logic [PW-1:0] F_PC_i = '0;
  logic [PW-1:0] F_nPC_i = '0;
  logic          F_commit_i = 1'b0;
  logic          F_train_predict_i = 1'b0;
  logic          F_train_vaild_i = 1'b0;
  logic [HW-1:0] F_train_history_i = '0;
  logic          D_valid_o;
  logic          D_ready_i = 1'b0;
  logic [IW-1:0] FD_instr_o;
  logic [PW-1:0] FD_PC_o;
  logic [PW-1:0] FD_nPC_o;
  logic          FD_commit_o;
  logic          FD_train_predict_o;
  logic          FD_train_vaild_o;
  logic [HW-1:0] FD_train_history_o;
  logic [CW-1:0] count_o;
  logic          afull_o;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk_i = ~clk_i;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .INSTR_W  (IW),
    .PC_W     (PW),
    .HIST_W   (HW),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .clk_i              (clk_i),
    .rst                (rst),
    .flush_i            (flush_i),
    .F_valid_i          (F_valid_i),
    .F_ready_o          (F_ready_o),
    .F_instr_i          (F_instr_i),
    .F_PC_i             (F_PC_i),
    .F_nPC_i            (F_nPC_i),
    .F_commit_i         (F_commit_i),
    .F_train_predict_i  (F_train_predict_i),
    .F_train_vaild_i    (F_train_vaild_i),
    .F_train_history_i  (F_train_history_i),
    .D_valid_o          (D_valid_o),
    .D_ready_i          (D_ready_i),
    .FD_instr_o         (FD_instr_o),
    .FD_PC_o            (FD_PC_o),
    .FD_nPC_o           (FD_nPC_o),
    .FD_commit_o        (FD_commit_o),
    .FD_train_predict_o (FD_train_predict_o),
    .FD_train_vaild_o   (FD_train_vaild_o),
    .FD_train_history_o (FD_train_history_o),
    .count_o            (count_o),
    .afull_o            (afull_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against what the model says decode and fetch should see now.
  task automatic check_all(input string phase);
    int   cnt;
    ent_t head;
    cnt = model_q.size();
    if (cnt > 0) begin
      head = model_q[0];
    end else begin
      head.instr = NOP_INSTR; head.pc = NOP_PC; head.npc = NOP_NPC;
      head.commit = NOP_COMMIT; head.pred = 1'b0; head.tv = 1'b0; head.hist = '0;
    end
    check_eq({phase, ".count"},   64'(count_o),   64'(cnt));
    check_eq({phase, ".d_valid"}, 64'(D_valid_o), 64'(cnt != 0));
    check_eq({phase, ".f_ready"}, 64'(F_ready_o), 64'(cnt != DEPTH));
    check_eq({phase, ".afull"},   64'(afull_o),   64'(cnt >= AFULL_TH));
    check_eq({phase, ".instr"},   64'(FD_instr_o),         64'(head.instr));
    check_eq({phase, ".pc"},      64'(FD_PC_o),            64'(head.pc));
    check_eq({phase, ".npc"},     64'(FD_nPC_o),           64'(head.npc));
    check_eq({phase, ".commit"},  64'(FD_commit_o),        64'(head.commit));
    check_eq({phase, ".predict"}, 64'(FD_train_predict_o), 64'(head.pred));
    check_eq({phase, ".vaild"},   64'(FD_train_vaild_o),   64'(head.tv));
    check_eq({phase, ".hist"},    64'(FD_train_history_o), 64'(head.hist));
  endtask

  // Called at a falling edge: drive one cycle of stimulus, advance the model, check after the edge.
  task automatic cycle(input string phase, input logic fv, input logic dr, input logic fl,
                       input logic [PW-1:0] pc);
    ent_t e;
    bit   do_push;
    bit   do_pop;
    e.instr = IW'($urandom);
    e.pc    = pc;
    e.npc   = PW'($urandom);
    e.commit = 1'($urandom_range(0, 1));
    e.pred   = 1'($urandom_range(0, 1));
    e.tv     = 1'($urandom_range(0, 1));
    e.hist   = HW'($urandom);
    F_valid_i = fv; D_ready_i = dr; flush_i = fl;
    F_instr_i = e.instr; F_PC_i = e.pc; F_nPC_i = e.npc; F_commit_i = e.commit;
    F_train_predict_i = e.pred; F_train_vaild_i = e.tv; F_train_history_i = e.hist;
    do_push = fv && (model_q.size() != DEPTH) && !fl;
    do_pop  = dr && (model_q.size() != 0) && !fl;
    @(posedge clk_i);
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    @(negedge clk_i);
    check_all(phase);
    $display("cyc %-8s fv=%0b dr=%0b fl=%0b pc=0x%08h -> count=%0d head_pc=0x%08h",
             phase, fv, dr, fl, pc, count_o, FD_PC_o);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PW-1:0] pc;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk_i);
    check_all("reset");
    rst = 1'b1;

    // Fill with decode stalled; a fifth offer at full must be refused.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, 1'b0, PW'(4 * i));
    cycle("full", 1'b1, 1'b0, 1'b0, PW'(32'h10));

    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1, 1'b0, '0);
    cycle("empty", 1'b0, 1'b1, 1'b0, '0);

    pc = PW'(32'h100);
    cycle("stream0", 1'b1, 1'b0, 1'b0, pc);
    for (int i = 0; i < 20; i++) begin
      pc = pc + PW'(4);
      cycle("stream", 1'b1, 1'b1, 1'b0, pc);
    end

    cycle("pre_fl", 1'b1, 1'b0, 1'b0, PW'(32'h200));
    cycle("pre_fl", 1'b1, 1'b0, 1'b0, PW'(32'h204));
    cycle("flush", 1'b1, 1'b1, 1'b1, PW'(32'hDEAD));
    cycle("flush_h", 1'b1, 1'b0, 1'b1, PW'(32'hBEEF));
    cycle("post_fl", 1'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, 1'b0, 1'b0, PW'(32'h300 + 4 * i));
    cycle("fullpop", 1'b1, 1'b1, 1'b0, PW'(32'h400));
    cycle("refill", 1'b1, 1'b0, 1'b0, PW'(32'h404));

    cycle("pre_rst", 1'b0, 1'b0, 1'b1, '0);
    cycle("pre_rst", 1'b1, 1'b0, 1'b0, PW'(32'h500));
    cycle("pre_rst", 1'b1, 1'b0, 1'b0, PW'(32'h504));
    F_valid_i = 1'b0; D_ready_i = 1'b0;
    #2 rst = 1'b0;
    model_q.delete();
    #1 check_all("async_rst");
    $display("cyc async_rst count=%0d d_valid=%0b", count_o, D_valid_o);
    @(negedge clk_i);
    check_all("in_rst");
    rst = 1'b1;
    cycle("post_rst", 1'b1, 1'b0, 1'b0, PW'(32'h600));

    for (int i = 0; i < 400; i++) begin
      cycle("random", ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0), PW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised fetch-to-decode queue that takes over from the single-entry FD pipeline register. It buffers up to DEPTH fetched instructions together with their PC, predicted next PC, commit flag and branch-predictor training fields. Fetch and decode are decoupled by valid/ready handshakes, and a flush input empties the queue in one cycle. Decode sees a first-word-fall-through head entry, and sees nop fields whenever the queue is empty.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2
- INSTR_W, `INSTR_WIDTH, instruction width
- PC_W, `PC_WIDTH, PC / nPC width
- HIST_W, `history_WIDTH, predictor history width
- AFULL_TH, DEPTH-1, occupancy at or above which afull_o asserts; range 1..DEPTH

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- flush_i  in  1  discard all entries (redirect / mispredict)
- F_valid_i  in  1  fetch offers an entry
- F_ready_o  out  1  queue can accept an entry
- F_instr_i, F_PC_i, F_nPC_i  in  INSTR_W / PC_W / PC_W  entry payload
- F_commit_i, F_train_predict_i, F_train_vaild_i  in  1 each  entry flags
- F_train_history_i  in  HIST_W  predictor history
- D_valid_o  out  1  head entry is valid
- D_ready_i  in  1  decode consumes the head this cycle
- FD_instr_o, FD_PC_o, FD_nPC_o, FD_commit_o, FD_train_predict_o, FD_train_vaild_o, FD_train_history_o  out  matching widths  head payload
- count_o  out  $clog2(DEPTH)+1  current occupancy
- afull_o  out  1  count_o >= AFULL_TH

## Operation
- push = F_valid_i & F_ready_o & ~flush_i.
- pop = D_valid_o & D_ready_i & ~flush_i.
- Storage is a circular buffer:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count is tracked separately.
- Push writes the payload at wr_ptr, then wr_ptr increments.
- Pop increments rd_ptr.
- Count update:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged
- Flush takes priority over everything:
  - next cycle wr_ptr = rd_ptr = 0 and count = 0.
  - A push or pop in the flush cycle is ignored.
- F_ready_o = (count != DEPTH).
  - It depends only on registered state, so there is no combinational path from D_ready_i.
  - At full with a simultaneous pop, the push is still refused.
- D_valid_o = (count != 0).
- Head payload outputs:
  - When D_valid_o is high, all FD_* outputs show entry[rd_ptr].
  - When D_valid_o is low, they are forced to nop values: `nop_instr, `nop_PC, `nop_nPC, `nop_commit; train_predict, train_vaild and history = 0.
  - Decode may therefore ignore D_valid_o and still see a legal bubble.
- Stall is expressed by D_ready_i low:
  - The head holds, and all FD_* outputs stay stable.
  - Fetch continues filling until full.
- Storage array is not reset. Forcing nop while empty keeps the outputs defined.

## Timing
- Reset (rst low, asynchronous): pointers = 0, count_o = 0, D_valid_o = 0, F_ready_o = 1, afull_o = 0, FD_* = nop values. Every field is reset, including train_predict.
- Leaving reset: the first push is accepted on the first rising edge after rst goes high.
- Latency: a push at edge N makes the entry visible on FD_* with D_valid_o = 1 after edge N. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained, provided 0 < count < DEPTH.
- Empty boundary: push and pop in the same cycle are impossible, because pop requires D_valid_o.
- Full boundary: F_ready_o = 0 for the whole cycle. A pop frees a slot and F_ready_o rises after that edge.
- Flush: after the flush edge, D_valid_o = 0, FD_* = nop, F_ready_o = 1 and count_o = 0. Flush held for several cycles keeps the queue empty.
- Reset asserted mid-operation: all contents are lost immediately, with the same values as at reset.

## Structure
- Shared constants in define.v:
  - `nop_instr, `nop_PC, `nop_nPC, `nop_commit, `INSTR_WIDTH, `PC_WIDTH, `history_WIDTH
  - Add `FQ_DEPTH as the default depth.
- One sub-module, fq_storage:
  - DEPTH x (INSTR_W + 2*PC_W + 3 + HIST_W) register array.
  - Synchronous write port and asynchronous read port.
- Pointers, count, handshake and nop muxing live in fetch_queue.
- Intended implementation size is 150–250 lines.

## Test plan
- Reset and fill, DEPTH=4:
  - Stimulus: reset, then push 4 entries with PC 0x00, 0x04, 0x08, 0x0C while D_ready_i=0.
  - Required: count_o reaches 4, F_ready_o=0, afull_o=1 from count 3, FD_PC_o=0x00 is stable throughout.
- Drain order:
  - Stimulus: from full, hold D_ready_i=1 for 4 cycles.
  - Required: FD_PC_o shows 0x00, 0x04, 0x08, 0x0C, then D_valid_o=0 and FD_instr_o=`nop_instr.
- Streaming:
  - Stimulus: with count 1, push and pop every cycle for 20 cycles.
  - Required: count_o stays 1, PCs exit in order, wrap-around crosses the pointer boundary at least 4 times.
- Flush priority:
  - Stimulus: count 3, flush_i=1 together with F_valid_i=1 and D_ready_i=1.
  - Required: next cycle count_o=0, D_valid_o=0, F_ready_o=1; the offered entry never appears.
- Full with pop:
  - Stimulus: count 4, F_valid_i=1, D_ready_i=1.
  - Required: push refused, count_o=3; next cycle push accepted, count_o=4.
- Asynchronous reset mid-stream:
  - Stimulus: drop rst between edges while count 2.
  - Required: D_valid_o, count_o and all FD_* fields go to nop/0 without waiting for a clock edge.
